lfsr_prbs_checker: RTL and testbench

//  Receive-side companion to the on-chip LFSR pattern generator. Takes a serial bit stream

---
 rtl/lfsr_prbs_checker.sv | 170 +++++++++++++++++
 tb/tb_lfsr_prbs_checker.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prbs_checker.sv
// lfsr_prbs_checker
// Receive-side checker for the on-chip LFSR pattern generator. It rebuilds the
// generator state from the incoming feedback bits, predicts every following
// bit, reports lock status and keeps error/bit counters for BER measurement.
module lfsr_prbs_checker #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] TAPS      = 32'h80200003,
  parameter int               SYNC_BITS = 16,
  parameter int               WINDOW    = 256,
  parameter int               LOSS_ERRS = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        bit_valid_i,
  input  logic        bit_i,
  input  logic        clear_i,
  output logic        locked_o,
  output logic        err_o,
  output logic [15:0] err_count_o,
  output logic [23:0] bit_count_o,
  output logic [1:0]  state_o
);

  localparam int FILL_W   = $clog2(WIDTH + 1);
  localparam int STREAK_W = $clog2(SYNC_BITS + 1);
  localparam int WBIT_W   = $clog2(WINDOW + 1);
  localparam int WERR_W   = $clog2(LOSS_ERRS + 1);

  typedef enum logic [1:0] {
    ACQUIRE = 2'b00,
    VERIFY  = 2'b01,
    LOCKED  = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [WBIT_W-1:0]   win_bits_q, win_bits_d;
  logic [WERR_W-1:0]   win_errs_q, win_errs_d;
  logic [15:0]         err_count_q, err_count_d;
  logic [23:0]         bit_count_q, bit_count_d;
  logic                err_q, err_d;
  logic                locked_q;

  logic                pred;
  logic                mismatch;
  logic [WIDTH-1:0]    shift_in;
  logic [FILL_W-1:0]   fill_inc;
  logic [WBIT_W-1:0]   win_bits_inc;
  logic [WERR_W-1:0]   win_errs_inc;

  // Prediction from the rebuilt state plus the candidate next values of the
  // shift register and the saturating/window counters.
  always_comb begin
    pred         = ^(shift_q & TAPS);
    mismatch     = bit_i ^ pred;
    shift_in     = {shift_q[WIDTH-2:0], bit_i};
    fill_inc     = (fill_q == FILL_W'(WIDTH)) ? fill_q : fill_q + 1'b1;
    win_bits_inc = win_bits_q + 1'b1;
    win_errs_inc = win_errs_q + {{(WERR_W-1){1'b0}}, mismatch};
  end

  // Next-state logic: sync FSM, counters, and the clear pulse which overrides
  // any counter update on the same edge.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    fill_d      = fill_q;
    streak_d    = streak_q;
    win_bits_d  = win_bits_q;
    win_errs_d  = win_errs_q;
    err_count_d = err_count_q;
    bit_count_d = bit_count_q;
    err_d       = 1'b0;

    if (bit_valid_i) begin
      shift_d = shift_in;
      unique case (state_q)
        ACQUIRE: begin
          fill_d = fill_inc;
          if ((fill_inc == FILL_W'(WIDTH)) && (shift_in != '0)) begin
            state_d  = VERIFY;
            streak_d = '0;
          end
        end
        VERIFY: begin
          if (mismatch) begin
            err_d   = 1'b1;
            fill_d  = '0;
            state_d = ACQUIRE;
          end else begin
            streak_d = streak_q + 1'b1;
            if (streak_q == STREAK_W'(SYNC_BITS - 1)) begin
              state_d    = LOCKED;
              win_bits_d = '0;
              win_errs_d = '0;
            end
          end
        end
        LOCKED: begin
          if (bit_count_q != '1) begin
            bit_count_d = bit_count_q + 1'b1;
          end
          if (mismatch) begin
            err_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + 1'b1;
            end
          end
          if (win_errs_inc == WERR_W'(LOSS_ERRS)) begin
            state_d    = ACQUIRE;
            fill_d     = '0;
            win_bits_d = '0;
            win_errs_d = '0;
          end else if (win_bits_inc == WBIT_W'(WINDOW)) begin
            win_bits_d = '0;
            win_errs_d = '0;
          end else begin
            win_bits_d = win_bits_inc;
            win_errs_d = win_errs_inc;
          end
        end
        default: begin
          state_d = ACQUIRE;
          fill_d  = '0;
        end
      endcase
    end

    if (clear_i) begin
      err_count_d = '0;
      bit_count_d = '0;
    end
  end

  // State and output registers; reset discards all sync progress and counts.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ACQUIRE;
      shift_q     <= '0;
      fill_q      <= '0;
      streak_q    <= '0;
      win_bits_q  <= '0;
      win_errs_q  <= '0;
      err_count_q <= '0;
      bit_count_q <= '0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      fill_q      <= fill_d;
      streak_q    <= streak_d;
      win_bits_q  <= win_bits_d;
      win_errs_q  <= win_errs_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
      err_q       <= err_d;
      locked_q    <= (state_d == LOCKED);
    end
  end

  assign locked_o    = locked_q;
  assign err_o       = err_q;
  assign err_count_o = err_count_q;
  assign bit_count_o = bit_count_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// tb_lfsr_prbs_checker
// Drives generator streams (clean, corrupted, random, gapped) into the checker
// and compares every cycle against a bit-history reference model.
module tb_lfsr_prbs_checker;

  localparam logic [31:0] TAPS_M = 32'h80200003;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        bit_valid_i = 1'b0;
  logic        bit_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        locked_o;
  logic        err_o;
  logic [15:0] err_count_o;
  logic [23:0] bit_count_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  // reference model: history of received bits, newest first
  logic       m_hist[$];
  logic [1:0] m_state;
  int         m_fill, m_streak, m_wb, m_we, m_ec, m_bc;
  logic       m_err, m_locked;

  logic [31:0] gen;

  lfsr_prbs_checker dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .bit_valid_i (bit_valid_i),
    .bit_i       (bit_i),
    .clear_i     (clear_i),
    .locked_o    (locked_o),
    .err_o       (err_o),
    .err_count_o (err_count_o),
    .bit_count_o (bit_count_o),
    .state_o     (state_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic gen_bit(output logic b);
    b   = ^(gen & TAPS_M);
    gen = {gen[30:0], b};
  endtask

  task automatic model_step(input logic v, input logic b, input logic clr, input logic rst);
    logic pred;
    logic nz;
    m_err = 1'b0;
    if (rst) begin
      m_state = 2'd0; m_fill = 0; m_streak = 0; m_wb = 0; m_we = 0;
      m_ec = 0; m_bc = 0;
      for (int k = 0; k < 32; k++) m_hist[k] = 1'b0;
    end else begin
      if (v) begin
        pred = 1'b0;
        for (int k = 0; k < 32; k++) if (TAPS_M[k]) pred ^= m_hist[k];
        m_hist.push_front(b);
        void'(m_hist.pop_back());
        case (m_state)
          2'd0: begin
            if (m_fill < 32) m_fill++;
            nz = 1'b0;
            for (int k = 0; k < 32; k++) if (m_hist[k]) nz = 1'b1;
            if (m_fill == 32 && nz) begin
              m_state = 2'd1;
              m_streak = 0;
            end
          end
          2'd1: begin
            if (b != pred) begin
              m_err = 1'b1; m_fill = 0; m_state = 2'd0;
            end else begin
              m_streak++;
              if (m_streak == 16) begin
                m_state = 2'd2; m_wb = 0; m_we = 0;
              end
            end
          end
          default: begin
            if (m_bc < 24'hFFFFFF) m_bc++;
            m_wb++;
            if (b != pred) begin
              m_err = 1'b1;
              if (m_ec < 16'hFFFF) m_ec++;
              m_we++;
            end
            if (m_we == 8) begin
              m_state = 2'd0; m_fill = 0; m_wb = 0; m_we = 0;
            end else if (m_wb == 256) begin
              m_wb = 0; m_we = 0;
            end
          end
        endcase
      end
      if (clr) begin
        m_ec = 0;
        m_bc = 0;
      end
    end
    m_locked = (m_state == 2'd2);
  endtask

  task automatic check_const(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    checks++;
    assert (state_o === m_state) else begin
      errors++;
      $error("[TB] FAIL %s state_o observed=%0h expected=%0h", tag, state_o, m_state);
    end
    checks++;
    assert (locked_o === m_locked) else begin
      errors++;
      $error("[TB] FAIL %s locked_o observed=%0h expected=%0h", tag, locked_o, m_locked);
    end
    checks++;
    assert (err_o === m_err) else begin
      errors++;
      $error("[TB] FAIL %s err_o observed=%0h expected=%0h", tag, err_o, m_err);
    end
    checks++;
    assert (err_count_o === 16'(m_ec)) else begin
      errors++;
      $error("[TB] FAIL %s err_count_o observed=%0h expected=%0h", tag, err_count_o, m_ec);
    end
    checks++;
    assert (bit_count_o === 24'(m_bc)) else begin
      errors++;
      $error("[TB] FAIL %s bit_count_o observed=%0h expected=%0h", tag, bit_count_o, m_bc);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic b, input logic clr, input logic rst,
                                input string tag);
    bit_valid_i = v;
    bit_i       = b;
    clear_i     = clr;
    reset_i     = rst;
    @(posedge clk_i);
    model_step(v, b, clr, rst);
    #1;
    check_output(tag);
  endtask

  initial begin
    logic b;
    logic r;
    logic saw_err;
    logic lost;
    int   pulses;
    int   n;
    int   valid_cnt;
    logic [1:0]  p_state;
    logic        p_locked;
    logic [15:0] p_ec;
    logic [23:0] p_bc;

    for (int k = 0; k < 32; k++) m_hist.push_back(1'b0);

    $display("[TB] reset");
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, "reset");
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, "reset_valid");
    check_const("reset_state", 32'(state_o), 32'd0);

    $display("[TB] clean stream acquisition");
    gen = 32'h1;
    saw_err = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      gen_bit(b);
      apply_stimulus(1'b1, b, 1'b0, 1'b0, "clean");
      saw_err |= err_o;
      if (i == 31) check_const("acq_before_fill", 32'(state_o), 32'd0);
      if (i == 32) check_const("verify_at_32", 32'(state_o), 32'd1);
      if (i == 47) check_const("verify_at_47", 32'(state_o), 32'd1);
      if (i == 48) check_const("locked_at_48", 32'(state_o), 32'd2);
    end
    check_const("clean_locked", 32'(locked_o), 32'd1);
    check_const("clean_no_err", 32'(saw_err), 32'd0);
    check_const("clean_err_count", 32'(err_count_o), 32'd0);
    check_const("clean_bit_count", 32'(bit_count_o), 32'd152);

    $display("[TB] single flipped bit");
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      gen_bit(b);
      if (i == 0) b = ~b;
      apply_stimulus(1'b1, b, 1'b0, 1'b0, "flip");
      pulses += int'(err_o);
    end
    check_const("flip_pulses", 32'(pulses), 32'd4);
    check_const("flip_err_count", 32'(err_count_o), 32'd4);
    check_const("flip_locked", 32'(locked_o), 32'd1);
    for (int i = 0; i < 8; i++) begin
      gen_bit(b);
      apply_stimulus(1'b1, b, 1'b0, 1'b0, "flip_tail");
    end

    $display("[TB] random bits until loss of lock");
    lost = 1'b0;
    n = 0;
    while (!lost && n < 64) begin
      gen_bit(b);
      r = 1'($urandom_range(0, 1));
      apply_stimulus(1'b1, r, 1'b0, 1'b0, "random");
      if (!locked_o) lost = 1'b1;
      n++;
    end
    check_const("loss_seen", 32'(lost), 32'd1);
    check_const("loss_state", 32'(state_o), 32'd0);
    for (int i = 1; i <= 48; i++) begin
      gen_bit(b);
      apply_stimulus(1'b1, b, 1'b0, 1'b0, "relock");
      if (i == 47) check_const("relock_not_yet", 32'(locked_o), 32'd0);
      if (i == 48) check_const("relock_at_48", 32'(locked_o), 32'd1);
    end

    $display("[TB] all-zero input");
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, "reset_zero");
    saw_err = 1'b0;
    for (int i = 0; i < 100; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, "zeros");
      saw_err |= err_o;
    end
    check_const("zeros_state", 32'(state_o), 32'd0);
    check_const("zeros_locked", 32'(locked_o), 32'd0);
    check_const("zeros_no_err", 32'(saw_err), 32'd0);

    $display("[TB] gapped valid");
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, "reset_gap");
    gen = 32'h1;
    valid_cnt = 0;
    for (int c = 0; c < 96; c++) begin
      if (c % 2 == 0) begin
        gen_bit(b);
        apply_stimulus(1'b1, b, 1'b0, 1'b0, "gap_valid");
        valid_cnt++;
        if (valid_cnt == 47) check_const("gap_not_locked", 32'(locked_o), 32'd0);
        if (valid_cnt == 48) check_const("gap_locked", 32'(locked_o), 32'd1);
      end else begin
        p_state = state_o; p_locked = locked_o; p_ec = err_count_o; p_bc = bit_count_o;
        apply_stimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "gap_idle");
        check_const("gap_hold_state", 32'(state_o), 32'(p_state));
        check_const("gap_hold_locked", 32'(locked_o), 32'(p_locked));
        check_const("gap_hold_counts", {8'(p_ec), p_bc}, {8'(err_count_o), bit_count_o});
      end
    end

    $display("[TB] reset mid-lock and clear with error");
    for (int i = 0; i < 10; i++) begin
      gen_bit(b);
      apply_stimulus(1'b1, b, 1'b0, 1'b0, "pre_reset");
    end
    gen_bit(b);
    apply_stimulus(1'b1, ~b, 1'b1, 1'b1, "mid_reset");
    check_const("mid_reset_locked", 32'(locked_o), 32'd0);
    check_const("mid_reset_state", 32'(state_o), 32'd0);
    check_const("mid_reset_err", 32'(err_o), 32'd0);
    check_const("mid_reset_counts", {8'(err_count_o), bit_count_o}, 32'd0);
    for (int i = 0; i < 60; i++) begin
      gen_bit(b);
      apply_stimulus(1'b1, b, 1'b0, 1'b0, "post_reset");
    end
    gen_bit(b);
    apply_stimulus(1'b1, ~b, 1'b1, 1'b0, "clear_err");
    check_const("clear_err_pulse", 32'(err_o), 32'd1);
    check_const("clear_err_count", 32'(err_count_o), 32'd0);
    check_const("clear_bit_count", 32'(bit_count_o), 32'd0);
    check_const("clear_keeps_lock", 32'(locked_o), 32'd1);
    for (int i = 0; i < 40; i++) begin
      gen_bit(b);
      apply_stimulus(1'b1, b, 1'b0, 1'b0, "post_clear");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
